// File: rtl/frame_packer.sv
// frame_packer: groups aligner words into fixed-size frames with a count/status trailer, buffered in a FWFT FIFO.
module frame_packer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 6,
  parameter int FRAME_WORDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_sync,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_vld,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_vld,
  input  logic                i_rdy,
  output logic                o_sop,
  output logic                o_eop,
  output logic [ADDR_W:0]     o_level,
  output logic [15:0]         o_drop_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, COLLECT, TRAILER} state_t;
  state_t st;
  logic [DATA_W+1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0] level;
  logic [15:0] ocnt, scnt, drop_cnt;
  logic trunc, drop, restart_pend;
  logic room1, room2, push, pop, drop_inc, last;
  logic [DATA_W+1:0] wdata;
  always_comb begin
    room1 = level < (ADDR_W+1)'(DEPTH);
    room2 = level <= (ADDR_W+1)'(DEPTH - 2);
    pop = o_vld && i_rdy;
    push = (st == COLLECT && i_vld && !i_sync && room2) || (st == TRAILER && room1);
    wdata = st == TRAILER ? {1'b1, scnt == 16'd0, trunc, drop, 14'b0, scnt}
                          : {1'b0, scnt == 16'd0, i_data};
    drop_inc = i_vld && (st == TRAILER || (st == COLLECT && (i_sync || !room2)));
    last = ocnt + 16'd1 == 16'(FRAME_WORDS);
  end
  assign o_vld      = level != '0;
  assign o_data     = o_vld ? mem[rptr][DATA_W-1:0] : '0;
  assign o_sop      = o_vld && mem[rptr][DATA_W];
  assign o_eop      = o_vld && mem[rptr][DATA_W+1];
  assign o_level    = level;
  assign o_drop_cnt = drop_cnt;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
  // A sync arriving while the trailer goes out restarts collection straight away.
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ocnt <= '0;
      scnt <= '0;
      trunc <= 1'b0;
      drop <= 1'b0;
      restart_pend <= 1'b0;
    end else begin
      case (st)
        IDLE: if (i_sync) begin
          st <= COLLECT;
          ocnt <= '0;
          scnt <= '0;
          trunc <= 1'b0;
          drop <= 1'b0;
          restart_pend <= 1'b0;
        end
        COLLECT: if (i_sync) begin
          if (ocnt != 16'd0) begin
            trunc <= 1'b1;
            restart_pend <= 1'b1;
            st <= TRAILER;
          end
        end else if (i_vld) begin
          ocnt <= ocnt + 16'd1;
          if (room2) scnt <= scnt + 16'd1;
          else drop <= 1'b1;
          if (last) st <= TRAILER;
        end
        TRAILER: begin
          if (i_sync) restart_pend <= 1'b1;
          if (room1) begin
            st <= (restart_pend || i_sync) ? COLLECT : IDLE;
            ocnt <= '0;
            scnt <= '0;
            trunc <= 1'b0;
            drop <= 1'b0;
            restart_pend <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer: scoreboard bench for frame_packer with a 4-word and a 16-word instance.
module tb_frame_packer;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic sync = 0, vld = 0, rdy = 1;
  logic [31:0] din = 0, dout;
  logic ov, sop, eop;
  logic [3:0] lvl;
  logic [15:0] dc;
  logic sync16 = 0, vld16 = 0, rdy16 = 0;
  logic [31:0] din16 = 0, dout16;
  logic ov16, sop16, eop16;
  logic [3:0] lvl16;
  logic [15:0] dc16;
  int checks = 0, failures = 0;
  logic [33:0] q4[$], q16[$];

  frame_packer #(.DATA_W(32), .ADDR_W(3), .FRAME_WORDS(4)) u4 (
    .clk(clk), .rst(rst), .i_sync(sync), .i_data(din), .i_vld(vld),
    .o_data(dout), .o_vld(ov), .i_rdy(rdy), .o_sop(sop), .o_eop(eop),
    .o_level(lvl), .o_drop_cnt(dc));
  frame_packer #(.DATA_W(32), .ADDR_W(3), .FRAME_WORDS(16)) u16 (
    .clk(clk), .rst(rst), .i_sync(sync16), .i_data(din16), .i_vld(vld16),
    .o_data(dout16), .o_vld(ov16), .i_rdy(rdy16), .o_sop(sop16), .o_eop(eop16),
    .o_level(lvl16), .o_drop_cnt(dc16));

  task automatic chk(input string n, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && ov && rdy) begin
      if (q4.size() == 0) chk("u4_unexpected_word", {eop, sop, dout}, 34'h0);
      else chk("u4_out", {eop, sop, dout}, q4.pop_front());
    end
  always @(negedge clk)
    if (!rst && ov16 && rdy16) begin
      if (q16.size() == 0) chk("u16_unexpected_word", {eop16, sop16, dout16}, 34'h0);
      else chk("u16_out", {eop16, sop16, dout16}, q16.pop_front());
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] d);
    vld = 1; din = d; tick(); vld = 0;
  endtask
  task automatic send16(input logic [31:0] d);
    vld16 = 1; din16 = d; tick(); vld16 = 0;
  endtask
  task automatic pulse_sync();
    sync = 1; tick(); sync = 0;
  endtask
  task automatic frame4(input logic [31:0] b);
    q4.push_back({2'b01, b + 32'h1});
    q4.push_back({2'b00, b + 32'h2});
    q4.push_back({2'b00, b + 32'h3});
    q4.push_back({2'b00, b + 32'h4});
    q4.push_back({2'b10, 32'h4});
    for (int i = 1; i <= 4; i++) send(b + i);
    tick();
  endtask
  task automatic drain(input string n);
    for (int i = 0; i < 200 && (q4.size() != 0 || ov); i++) tick();
    chk({n, "_pending"}, 34'(q4.size()), 34'd0);
    chk({n, "_level"}, 34'(lvl), 34'd0);
  endtask

  initial begin
    tick(); tick();
    chk("rst_vld", 34'(ov), 0);
    chk("rst_sop", 34'(sop), 0);
    chk("rst_eop", 34'(eop), 0);
    chk("rst_data", 34'(dout), 0);
    chk("rst_level", 34'(lvl), 0);
    chk("rst_drop", 34'(dc), 0);
    chk("rst16_vld", 34'(ov16), 0);
    rst = 0;
    for (int i = 0; i < 10; i++) send(32'hABCD0000 + i);
    tick();
    chk("idle_vld", 34'(ov), 0);
    chk("idle_level", 34'(lvl), 0);
    chk("idle_drop", 34'(dc), 0);
    pulse_sync();
    q4.push_back({2'b01, 32'h11111111});
    q4.push_back({2'b00, 32'h22222222});
    q4.push_back({2'b00, 32'h33333333});
    q4.push_back({2'b00, 32'h44444444});
    q4.push_back({2'b10, 32'h00000004});
    send(32'h11111111); send(32'h22222222); send(32'h33333333); send(32'h44444444);
    tick();
    drain("full");
    chk("full_drop", 34'(dc), 0);
    pulse_sync();
    q4.push_back({2'b01, 32'hA0000001});
    q4.push_back({2'b00, 32'hA0000002});
    q4.push_back({2'b10, 32'h80000002});
    send(32'hA0000001); send(32'hA0000002);
    pulse_sync();
    tick();
    frame4(32'hB0000000);
    drain("trunc");
    chk("trunc_drop", 34'(dc), 0);
    pulse_sync();
    sync = 1; vld = 1; din = 32'hDEADBEEF; tick(); sync = 0; vld = 0;
    chk("coll_drop", 34'(dc), 1);
    tick();
    chk("coll_no_trailer", 34'(ov), 0);
    frame4(32'hC0000000);
    drain("coll");
    chk("coll_drop_after", 34'(dc), 1);
    rdy = 0;
    pulse_sync();
    send(32'hE0000001); send(32'hE0000002);
    chk("mid_level", 34'(lvl), 2);
    rst = 1; tick(); rst = 0;
    chk("mid_vld", 34'(ov), 0);
    chk("mid_level_clr", 34'(lvl), 0);
    chk("mid_drop_clr", 34'(dc), 0);
    rdy = 1;
    pulse_sync();
    frame4(32'hD0000000);
    drain("post_rst");
    sync16 = 1; tick(); sync16 = 0;
    for (int i = 1; i <= 16; i++) send16(32'h10000000 + i);
    tick(); tick();
    chk("bp_level", 34'(lvl16), 8);
    chk("bp_drop", 34'(dc16), 9);
    chk("bp_head", {eop16, sop16, dout16}, {2'b01, 32'h10000001});
    for (int i = 1; i <= 7; i++) q16.push_back({1'b0, i == 1, 32'h10000000 + i});
    q16.push_back({2'b10, 32'h40000007});
    rdy16 = 1;
    for (int i = 0; i < 200 && (q16.size() != 0 || ov16); i++) tick();
    chk("bp_pending", 34'(q16.size()), 0);
    chk("bp_level_end", 34'(lvl16), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
